// File: rtl/dce_err_status_ctrl.sv
// -----------------------------------------------------------------------------
// dce_err_status_ctrl
//   Multi-channel error status / interrupt controller for the DCE unit. Each
//   channel tracks correctable errors against a programmable threshold
//   (ErrCount / ErrThreshold / ErrVld / ErrOvf) and logs uncorrectable errors
//   immediately. It also captures the info word of the logged event and
//   accepts write-1-to-clear updates from the CSR array.
//
//   Ports
//     clk, resetn           unit clock, synchronous active-low reset
//     ce_evt / uce_evt      per-channel one-cycle error pulses
//     evt_info              per-channel info word, valid with the pulses
//     det_en / int_en       per-channel detect / interrupt enables
//     err_thresh            per-channel correctable threshold
//     w1c_vld/w1c_ch/w1c_mask
//                           CSR W1C strobe, target channel, flag mask
//                           (bit0 ce_vld, bit1 ce_ovf, bit2 uce_vld, bit3 uce_ovf)
//     ce_cnt, ce_vld, ce_ovf, uce_vld, uce_ovf, err_info
//                           per-channel status registers
//     irq_c / irq_uc        registered correctable / uncorrectable interrupts
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// dce_err_chan
//   Status registers for one error channel.
//
//   Ports
//     clk, resetn        clock, synchronous active-low reset
//     ce_evt, uce_evt    correctable / uncorrectable pulses (already this channel)
//     det_en             detect enable; events are ignored while low
//     evt_info           info word qualifying the pulses
//     thr                correctable threshold
//     clr                decoded W1C mask for this channel (zero when not targeted)
//     cnt ... info       current status
// -----------------------------------------------------------------------------
module dce_err_chan #(
   parameter int W_CNT  = 8,
   parameter int W_INFO = 20
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              ce_evt,
   input  logic              uce_evt,
   input  logic              det_en,
   input  logic [W_INFO-1:0] evt_info,
   input  logic [W_CNT-1:0]  thr,
   input  logic [3:0]        clr,
   output logic [W_CNT-1:0]  cnt,
   output logic              ce_vld,
   output logic              ce_ovf,
   output logic              uce_vld,
   output logic              uce_ovf,
   output logic [W_INFO-1:0] info
);

   typedef struct packed {
      logic [W_CNT-1:0]  cnt;
      logic              ce_vld;
      logic              ce_ovf;
      logic              uce_vld;
      logic              uce_ovf;
      logic [W_INFO-1:0] info;
   } st_t;

   st_t  st_q, st_d;
   logic ce, uce;

   assign ce  = ce_evt  & det_en;
   assign uce = uce_evt & det_en;

   always_comb begin
      st_d = st_q;

      // W1C first; event updates below are applied on top so that a set
      // in the same cycle always wins over a clear.
      if (clr[0]) begin
         st_d.ce_vld = 1'b0;
         st_d.cnt    = '0;
      end
      if (clr[1]) st_d.ce_ovf  = 1'b0;
      if (clr[2]) st_d.uce_vld = 1'b0;
      if (clr[3]) st_d.uce_ovf = 1'b0;

      // Correctable path. Decisions use the pre-cycle flags, so a clear of
      // ce_vld colliding with an event still records the overflow.
      if (ce) begin
         if (st_q.ce_vld) begin
            st_d.ce_ovf = 1'b1;
         end else if (st_q.cnt < thr) begin
            st_d.cnt = st_q.cnt + W_CNT'(1);
         end else begin
            // Count saturates at the threshold; this branch also catches a
            // threshold lowered below the current count.
            st_d.ce_vld = 1'b1;
            st_d.cnt    = st_q.cnt;
            if (!st_q.uce_vld) st_d.info = evt_info;
         end
      end

      // Uncorrectable path. Placed after the CE path so its info capture
      // overrides a CE capture in the same cycle.
      if (uce) begin
         st_d.uce_vld = 1'b1;
         if (st_q.uce_vld) st_d.uce_ovf = 1'b1;
         else              st_d.info    = evt_info;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) st_q <= '0;
      else         st_q <= st_d;
   end

   assign cnt     = st_q.cnt;
   assign ce_vld  = st_q.ce_vld;
   assign ce_ovf  = st_q.ce_ovf;
   assign uce_vld = st_q.uce_vld;
   assign uce_ovf = st_q.uce_ovf;
   assign info    = st_q.info;

endmodule

module dce_err_status_ctrl #(
   parameter int N_CH   = 4,
   parameter int W_CNT  = 8,
   parameter int W_INFO = 20
) (
   input  logic                                      clk,
   input  logic                                      resetn,
   input  logic [N_CH-1:0]                           ce_evt,
   input  logic [N_CH-1:0]                           uce_evt,
   input  logic [N_CH*W_INFO-1:0]                    evt_info,
   input  logic [N_CH-1:0]                           det_en,
   input  logic [N_CH-1:0]                           int_en,
   input  logic [N_CH*W_CNT-1:0]                     err_thresh,
   input  logic                                      w1c_vld,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] w1c_ch,
   input  logic [3:0]                                w1c_mask,
   output logic [N_CH*W_CNT-1:0]                     ce_cnt,
   output logic [N_CH-1:0]                           ce_vld,
   output logic [N_CH-1:0]                           ce_ovf,
   output logic [N_CH-1:0]                           uce_vld,
   output logic [N_CH-1:0]                           uce_ovf,
   output logic [N_CH*W_INFO-1:0]                    err_info,
   output logic                                      irq_c,
   output logic                                      irq_uc
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   // When N_CH is not a power of two the select field can name channels
   // that do not exist; such writes are dropped.
   logic w1c_ok;
   assign w1c_ok = w1c_vld && (32'(w1c_ch) < 32'(N_CH));

   logic [N_CH-1:0][3:0] clr;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign clr[c] = (w1c_ok && (w1c_ch == CH_W'(c))) ? w1c_mask : 4'b0000;

      dce_err_chan #(
         .W_CNT  (W_CNT),
         .W_INFO (W_INFO)
      ) u_chan (
         .clk      (clk),
         .resetn   (resetn),
         .ce_evt   (ce_evt[c]),
         .uce_evt  (uce_evt[c]),
         .det_en   (det_en[c]),
         .evt_info (evt_info[c*W_INFO +: W_INFO]),
         .thr      (err_thresh[c*W_CNT +: W_CNT]),
         .clr      (clr[c]),
         .cnt      (ce_cnt[c*W_CNT +: W_CNT]),
         .ce_vld   (ce_vld[c]),
         .ce_ovf   (ce_ovf[c]),
         .uce_vld  (uce_vld[c]),
         .uce_ovf  (uce_ovf[c]),
         .info     (err_info[c*W_INFO +: W_INFO])
      );
   end

   // Interrupts are registered off the status registers: one cycle behind
   // the vld flags, gated by the current int_en.
   logic irq_c_q,  irq_c_d;
   logic irq_uc_q, irq_uc_d;

   always_comb begin
      irq_c_d  = |(ce_vld  & int_en);
      irq_uc_d = |(uce_vld & int_en);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         irq_c_q  <= 1'b0;
         irq_uc_q <= 1'b0;
      end else begin
         irq_c_q  <= irq_c_d;
         irq_uc_q <= irq_uc_d;
      end
   end

   assign irq_c  = irq_c_q;
   assign irq_uc = irq_uc_q;

endmodule

// File: tb/tb_dce_err_status_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dce_err_status_ctrl
//   Table-driven bench for dce_err_status_ctrl with five channels (so that
//   out-of-range W1C channel numbers are representable). Each vector holds
//   the inputs for one clock and the status expected right after that edge.
//   Thresholds: ch0=1 ch1=2 ch2=1 ch3=0 ch4=1.
// -----------------------------------------------------------------------------
module tb_dce_err_status_ctrl;

   localparam int N_CH   = 5;
   localparam int W_CNT  = 8;
   localparam int W_INFO = 20;
   localparam int CH_W   = 3;

   typedef struct packed {
      logic        rstn;
      logic [4:0]  ce, uce, det, ien;
      logic [19:0] info;
      logic        wv;
      logic [2:0]  wch;
      logic [3:0]  wm;
      logic [39:0] e_cnt;
      logic [4:0]  e_cv, e_co, e_uv, e_uo;
      logic        e_irqc, e_irquc;
      logic [2:0]  chk;
      logic [19:0] e_info;
   } vec_t;

   logic                     clk = 1'b0;
   logic                     resetn;
   logic [N_CH-1:0]          ce_evt, uce_evt, det_en, int_en;
   logic [N_CH*W_INFO-1:0]   evt_info;
   logic [4:0][7:0]          thr_v;
   logic                     w1c_vld;
   logic [CH_W-1:0]          w1c_ch;
   logic [3:0]               w1c_mask;
   logic [N_CH*W_CNT-1:0]    ce_cnt;
   logic [N_CH-1:0]          ce_vld, ce_ovf, uce_vld, uce_ovf;
   logic [N_CH*W_INFO-1:0]   err_info;
   logic                     irq_c, irq_uc;

   int   n_chk  = 0;
   int   n_fail = 0;
   vec_t v;
   vec_t tab[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   dce_err_status_ctrl #(.N_CH(N_CH), .W_CNT(W_CNT), .W_INFO(W_INFO)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .ce_evt     (ce_evt),
      .uce_evt    (uce_evt),
      .evt_info   (evt_info),
      .det_en     (det_en),
      .int_en     (int_en),
      .err_thresh (thr_v),
      .w1c_vld    (w1c_vld),
      .w1c_ch     (w1c_ch),
      .w1c_mask   (w1c_mask),
      .ce_cnt     (ce_cnt),
      .ce_vld     (ce_vld),
      .ce_ovf     (ce_ovf),
      .uce_vld    (uce_vld),
      .uce_ovf    (uce_ovf),
      .err_info   (err_info),
      .irq_c      (irq_c),
      .irq_uc     (irq_uc)
   );

   function automatic logic [39:0] cn(input int a0, a1, a2, a3, a4);
      return {a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
   endfunction

   // Return the input half of v to idle defaults; expectations carry over.
   task automatic clr_in();
      v.rstn = 1'b1; v.ce = '0; v.uce = '0; v.det = '1; v.ien = '1;
      v.info = '0;   v.wv = 1'b0; v.wch = '0; v.wm = '0;
   endtask

   task automatic add();
      tab.push_back(v);
      clr_in();
   endtask

   task automatic cmp(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL vec%0d %s: got %0h expected %0h", idx, nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t t, input int idx);
      vec_t e;
      @(negedge clk);
      resetn   = t.rstn;
      ce_evt   = t.ce;
      uce_evt  = t.uce;
      det_en   = t.det;
      int_en   = t.ien;
      evt_info = {5{t.info}};
      w1c_vld  = t.wv;
      w1c_ch   = t.wch;
      w1c_mask = t.wm;
      sb.push_back(t);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      cmp("ce_cnt",   idx, 64'(ce_cnt),  64'(e.e_cnt));
      cmp("ce_vld",   idx, 64'(ce_vld),  64'(e.e_cv));
      cmp("ce_ovf",   idx, 64'(ce_ovf),  64'(e.e_co));
      cmp("uce_vld",  idx, 64'(uce_vld), 64'(e.e_uv));
      cmp("uce_ovf",  idx, 64'(uce_ovf), 64'(e.e_uo));
      cmp("irq_c",    idx, 64'(irq_c),   64'(e.e_irqc));
      cmp("irq_uc",   idx, 64'(irq_uc),  64'(e.e_irquc));
      cmp("err_info", idx, 64'(err_info[e.chk*W_INFO +: W_INFO]), 64'(e.e_info));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      thr_v = {8'd1, 8'd0, 8'd1, 8'd2, 8'd1};
      v = '0;
      clr_in();

      // 0: reset
      v.rstn = 1'b0; add();
      // 1..6: ch1 counts to threshold 2, vld on third event, irq one later
      v.ce = 5'b00010; v.e_cnt = cn(0,1,0,0,0); v.chk = 3'd1; add();
      add();
      v.ce = 5'b00010; v.e_cnt = cn(0,2,0,0,0); add();
      add();
      v.ce = 5'b00010; v.info = 20'h11111; v.e_cv = 5'b00010; v.e_info = 20'h11111; add();
      v.e_irqc = 1'b1; add();
      // 7: overflow, count and info held
      v.ce = 5'b00010; v.info = 20'h22222; v.e_co = 5'b00010; add();
      // 8,9: W1C vld+ovf on ch1; irq drops a cycle later
      v.wv = 1'b1; v.wch = 3'd1; v.wm = 4'b0011;
      v.e_cnt = cn(0,0,0,0,0); v.e_cv = '0; v.e_co = '0; add();
      v.e_irqc = 1'b0; add();
      // 10..16: ch2 collisions
      v.ce = 5'b00100; v.info = 20'h33333; v.e_cnt = cn(0,0,1,0,0); v.chk = 3'd2; v.e_info = '0; add();
      v.ce = 5'b00100; v.info = 20'h33333; v.e_cv = 5'b00100; v.e_info = 20'h33333; add();
      v.ce = 5'b00100; v.info = 20'h3A3A3; v.wv = 1'b1; v.wch = 3'd2; v.wm = 4'b0001;
      v.e_cv = '0; v.e_cnt = cn(0,0,0,0,0); v.e_co = 5'b00100; v.e_irqc = 1'b1; add();
      v.ce = 5'b00100; v.info = 20'h3A3A3; v.wv = 1'b1; v.wch = 3'd2; v.wm = 4'b0011;
      v.e_cnt = cn(0,0,1,0,0); v.e_co = '0; v.e_irqc = 1'b0; add();
      v.ce = 5'b00100; v.info = 20'h44444; v.e_cv = 5'b00100; v.e_info = 20'h44444; add();
      v.ce = 5'b00100; v.info = 20'h3A3A3; v.wv = 1'b1; v.wch = 3'd2; v.wm = 4'b0011;
      v.e_cv = '0; v.e_cnt = cn(0,0,0,0,0); v.e_co = 5'b00100; v.e_irqc = 1'b1; add();
      v.wv = 1'b1; v.wch = 3'd2; v.wm = 4'b0010; v.e_co = '0; v.e_irqc = 1'b0; add();
      // 17..21: ch0 CE to vld, then UCE overrides info, then UCE overflow
      v.ce = 5'b00001; v.info = 20'h0AAAA; v.e_cnt = cn(1,0,0,0,0); v.chk = 3'd0; v.e_info = '0; add();
      v.ce = 5'b00001; v.info = 20'h0AAAA; v.e_cv = 5'b00001; v.e_info = 20'h0AAAA; add();
      v.uce = 5'b00001; v.info = 20'h05555; v.e_uv = 5'b00001; v.e_info = 20'h05555; v.e_irqc = 1'b1; add();
      v.e_irquc = 1'b1; add();
      v.uce = 5'b00001; v.info = 20'h0BBBB; v.e_uo = 5'b00001; add();
      // 22,23: ch3 thr=0, simultaneous CE+UCE, then CE overflow
      v.ce = 5'b01000; v.uce = 5'b01000; v.info = 20'h0CCCC;
      v.e_cv = 5'b01001; v.e_uv = 5'b01001; v.chk = 3'd3; v.e_info = 20'h0CCCC; add();
      v.ce = 5'b01000; v.info = 20'h0DDDD; v.e_co = 5'b01000; add();
      // 24..26: ch4 UCE first, CE reaching vld must not overwrite info
      v.uce = 5'b10000; v.info = 20'h01234; v.e_uv = 5'b11001; v.chk = 3'd4; v.e_info = 20'h01234; add();
      v.ce = 5'b10000; v.info = 20'h0FFFF; v.e_cnt = cn(1,0,0,0,1); add();
      v.ce = 5'b10000; v.info = 20'h0FFFF; v.e_cv = 5'b11001; add();
      // 27..30: UCE vs W1C collisions on ch0
      v.wv = 1'b1; v.wch = 3'd0; v.wm = 4'b1000; v.e_uo = '0; v.chk = 3'd0; v.e_info = 20'h05555; add();
      v.uce = 5'b00001; v.info = 20'h0BBBB; v.wv = 1'b1; v.wch = 3'd0; v.wm = 4'b0100; v.e_uo = 5'b00001; add();
      v.wv = 1'b1; v.wch = 3'd0; v.wm = 4'b1100; v.e_uv = 5'b11000; v.e_uo = '0; add();
      v.uce = 5'b00001; v.info = 20'h05A5A; v.wv = 1'b1; v.wch = 3'd0; v.wm = 4'b0100;
      v.e_uv = 5'b11001; v.e_info = 20'h05A5A; add();
      // 31..40: detection disabled, everything pulsing, status held
      for (int i = 0; i < 10; i++) begin
         v.det = '0; v.ce = '1; v.uce = '1; v.info = 20'h0EEEE; add();
      end
      // 41..43: interrupt enables
      v.ien = '0; v.e_irqc = 1'b0; v.e_irquc = 1'b0; add();
      v.ien = '0; add();
      v.ien = 5'b00010; add();
      // 44..46: out-of-range W1C ignored, in-range W1C on ch3 clears all
      v.wv = 1'b1; v.wch = 3'd5; v.wm = 4'b1111; v.e_irqc = 1'b1; v.e_irquc = 1'b1; add();
      v.wv = 1'b1; v.wch = 3'd7; v.wm = 4'b1111; add();
      v.wv = 1'b1; v.wch = 3'd3; v.wm = 4'b1111;
      v.e_cv = 5'b10001; v.e_co = '0; v.e_uv = 5'b10001; v.chk = 3'd3; v.e_info = 20'h0CCCC; add();
      // 47..49: mid-run reset with events present, then counting resumes
      v.rstn = 1'b0; v.ce = '1; v.uce = '1; v.info = 20'h0EEEE;
      v.e_cnt = '0; v.e_cv = '0; v.e_co = '0; v.e_uv = '0; v.e_uo = '0;
      v.e_irqc = 1'b0; v.e_irquc = 1'b0; v.e_info = '0; add();
      add();
      v.ce = 5'b00010; v.e_cnt = cn(0,1,0,0,0); v.chk = 3'd1; add();

      for (int i = 0; i < tab.size(); i++) run_vec(tab[i], i);

      // Threshold lowered below the current count on ch1 (count 2, thr 1):
      // the next event takes the vld branch without changing the count.
      v.ce = 5'b00010; v.e_cnt = cn(0,2,0,0,0); run_vec(v, 100); clr_in();
      thr_v[1] = 8'd1;
      v.ce = 5'b00010; v.info = 20'h0ABCD; v.e_cv = 5'b00010; v.e_info = 20'h0ABCD;
      run_vec(v, 101); clr_in();
      v.e_irqc = 1'b1; run_vec(v, 102);
      thr_v[1] = 8'd2;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
